// File: rtl/nested_loop_pkg.sv
// Shared types and default sizing for the nested loop counter.
package nested_loop_pkg;

    localparam int unsigned DEF_NUM_LEVELS = 3;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_TOTAL_W    = 64;

    // Run state of the loop nest.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One level count at the default width.
    typedef logic [DEF_CNT_W-1:0] level_cnt_t;

endpackage

// File: rtl/loop_level_counter.sv
// One level of the loop nest: modulo counter against a latched target with carry chain.
module loop_level_counter
    import nested_loop_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_target,
    input  logic [CNT_W-1:0] target,
    input  logic             carry_in,
    output logic [CNT_W-1:0] count,
    output logic             last,
    output logic             carry_out
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] target_q, target_d;

    // Stored target is never 0, so target_q-1 cannot underflow once a run is loaded.
    assign last      = (count_q == (target_q - CNT_W'(1)));
    assign carry_out = carry_in && last;
    assign count     = count_q;

    // Next count/target: load beats clear beats advance.
    always_comb begin
        count_d  = count_q;
        target_d = target_q;
        if (load_target) begin
            target_d = (target == '0) ? CNT_W'(1) : target;
            count_d  = '0;
        end else if (clear) begin
            count_d = '0;
        end else if (carry_in) begin
            count_d = last ? '0 : (count_q + CNT_W'(1));
        end
    end

    // Level registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= '0;
            target_q <= '0;
        end else begin
            count_q  <= count_d;
            target_q <= target_d;
        end
    end

endmodule

// File: rtl/nested_loop_counter.sv
// NUM_LEVELS-deep nested loop counter with single-shot/continuous runs, stall, abort and step tally.
module nested_loop_counter
    import nested_loop_pkg::*;
#(
    parameter int unsigned NUM_LEVELS = DEF_NUM_LEVELS,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned TOTAL_W    = DEF_TOTAL_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cont,
    input  logic                        abort,
    input  logic                        en,
    input  logic [NUM_LEVELS*CNT_W-1:0] targets,
    output logic [NUM_LEVELS*CNT_W-1:0] counts,
    output logic [NUM_LEVELS-1:0]       last,
    output logic                        busy,
    output logic                        step,
    output logic                        wrap,
    output logic                        done,
    output logic [TOTAL_W-1:0]          total
);

    state_e               state_q, state_d;
    logic                 cont_q, cont_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic                 wrap_q, wrap_d;
    logic                 done_q, done_d;

    logic [NUM_LEVELS:0]  carry;
    logic [NUM_LEVELS-1:0] last_w;
    logic                 in_run;
    logic                 all_last;
    logic                 load_c;
    logic                 clear_c;

    assign in_run   = (state_q == ST_RUN);
    assign all_last = &last_w;
    assign step     = en && in_run;
    assign busy     = in_run;
    assign last     = last_w;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign total    = total_q;

    // Targets are captured only on an accepted start; counts are forced to 0 outside RUN.
    assign load_c  = (state_q == ST_IDLE) && start && !abort;
    assign clear_c = abort || !in_run;

    // The final single-shot step is consumed but leaves the counts on their last values.
    assign carry[0] = step && !(all_last && !cont_q);

    // Carry chain of level counters, level 0 innermost.
    for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
        loop_level_counter #(
            .CNT_W (CNT_W)
        ) u_level (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear_c),
            .load_target (load_c),
            .target      (targets[gi*CNT_W +: CNT_W]),
            .carry_in    (carry[gi]),
            .count       (counts[gi*CNT_W +: CNT_W]),
            .last        (last_w[gi]),
            .carry_out   (carry[gi+1])
        );
    end

    // Next-state, mode, tally and pulse computation; abort overrides everything.
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        total_d = total_q;
        wrap_d  = carry[NUM_LEVELS];
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cont_d  = cont;
                    total_d = '0;
                end
            end
            ST_RUN: begin
                if (en) begin
                    total_d = total_q + TOTAL_W'(1);
                    if (all_last && !cont_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            cont_d  = cont_q;
            total_d = total_q;
            wrap_d  = 1'b0;
        end
        done_d = (state_d == ST_DONE);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cont_q  <= 1'b0;
            total_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            total_q <= total_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Self-checking bench for nested_loop_counter against a step-index reference model.
module tb_nested_loop_counter;
    import nested_loop_pkg::*;

    localparam int unsigned NL = 3;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic              abort = 1'b0;
    logic              en = 1'b0;
    logic [NL*CW-1:0]  targets = '0;
    logic [NL*CW-1:0]  counts;
    logic [NL-1:0]     last;
    logic              busy;
    logic              step;
    logic              wrap;
    logic              done;
    logic [TW-1:0]     total;

    int checks = 0;
    int errors = 0;

    nested_loop_counter #(.NUM_LEVELS(NL), .CNT_W(CW), .TOTAL_W(TW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cont    (cont),
        .abort   (abort),
        .en      (en),
        .targets (targets),
        .counts  (counts),
        .last    (last),
        .busy    (busy),
        .step    (step),
        .wrap    (wrap),
        .done    (done),
        .total   (total)
    );

    always #5 clk = ~clk;

    // Reference model: the nest position is a single step index decoded in mixed radix.
    int          m_state = 0;   // 0 idle, 1 running, 2 done
    longint      m_idx = 0;
    bit          m_cont = 1'b0;
    bit          m_wrap = 1'b0;
    bit          m_done = 1'b0;
    logic [63:0] m_total = '0;
    level_cnt_t  m_tgt [NL] = '{default: '0};

    function automatic longint m_span();
        longint p = 1;
        for (int i = 0; i < NL; i++) p = p * longint'(m_tgt[i]);
        return p;
    endfunction

    function automatic logic [NL*CW-1:0] exp_counts();
        logic [NL*CW-1:0] v;
        longint div = 1;
        v = '0;
        for (int i = 0; i < NL; i++) begin
            if (m_idx != 0 && m_tgt[i] != 0)
                v[i*CW +: CW] = CW'((m_idx / div) % longint'(m_tgt[i]));
            div = div * longint'(m_tgt[i]);
        end
        return v;
    endfunction

    function automatic logic [NL-1:0] exp_last();
        logic [NL*CW-1:0] cv;
        logic [NL-1:0] l;
        cv = exp_counts();
        for (int i = 0; i < NL; i++) l[i] = (cv[i*CW +: CW] == CW'(m_tgt[i] - 16'd1));
        return l;
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic c, input logic a,
                              input logic e, input logic [NL*CW-1:0] t);
        if (!r) begin
            m_state = 0; m_idx = 0; m_cont = 1'b0; m_total = '0;
            m_wrap = 1'b0; m_done = 1'b0;
            for (int i = 0; i < NL; i++) m_tgt[i] = '0;
        end else begin
            m_wrap = 1'b0;
            m_done = 1'b0;
            if (a) begin
                m_state = 0; m_idx = 0;
            end else if (m_state == 0) begin
                if (s) begin
                    for (int i = 0; i < NL; i++)
                        m_tgt[i] = (t[i*CW +: CW] == '0) ? 16'd1 : t[i*CW +: CW];
                    m_cont = c; m_idx = 0; m_total = '0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (e) begin
                    m_total = m_total + 64'd1;
                    if (m_idx == m_span() - 1) begin
                        if (m_cont) begin m_idx = 0; m_wrap = 1'b1; end
                        else begin m_state = 2; m_done = 1'b1; end
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
            end else begin
                m_state = 0; m_idx = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle outputs.
    task automatic tick(input logic s, input logic c, input logic a, input logic e);
        start = s; cont = c; abort = a; en = e;
        @(posedge clk);
        model_edge(rst, s, c, a, e, targets);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (counts !== '0) begin errors++; $display("FAIL reset_counts got=%h exp=0", counts); end
        checks++; if (last !== 3'b000) begin errors++; $display("FAIL reset_last got=%b exp=000", last); end
        checks++; if (busy !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL reset_busy_step got=%b%b exp=00", busy, step); end
        checks++; if (done !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_done_wrap got=%b%b exp=00", done, wrap); end
        checks++; if (total !== 64'd0) begin errors++; $display("FAIL reset_total got=%0d exp=0", total); end
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_shot();
        int done_at = 0;
        targets = {16'd2, 16'd2, 16'd3};
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || counts !== '0) begin errors++; $display("FAIL ss_first got=%b/%h exp=1/0", busy, counts); end
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (counts !== exp_counts()) begin errors++; $display("FAIL ss_counts i=%0d got=%h exp=%h", i, counts, exp_counts()); end
            if (i == 3) begin
                checks++; if (counts !== {16'd0, 16'd1, 16'd0}) begin errors++; $display("FAIL ss_carry got=%h exp=000000010000", counts); end
            end
            if (done === 1'b1) done_at = i;
        end
        checks++; if (done_at != 12) begin errors++; $display("FAIL ss_done_at got=%0d exp=12", done_at); end
        checks++; if (total !== 64'd12) begin errors++; $display("FAIL ss_total got=%0d exp=12", total); end
        checks++; if (counts !== {16'd1, 16'd1, 16'd2}) begin errors++; $display("FAIL ss_final got=%h exp=000100010002", counts); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || counts !== '0) begin errors++; $display("FAIL ss_idle got=%b%b/%h exp=00/0", done, busy, counts); end
    endtask

    task automatic test_stall();
        int done_at = 0;
        targets = {16'd2, 16'd2, 16'd3};
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 60 && done_at == 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, logic'(i % 2 == 1));
            checks++; if (counts !== exp_counts()) begin errors++; $display("FAIL stall_counts i=%0d got=%h exp=%h", i, counts, exp_counts()); end
            if (done === 1'b1) done_at = i;
        end
        checks++; if (done_at != 23) begin errors++; $display("FAIL stall_done_at got=%0d exp=23", done_at); end
        checks++; if (total !== 64'd12) begin errors++; $display("FAIL stall_total got=%0d exp=12", total); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_target_one();
        int done_at = 0;
        targets = {16'd1, 16'd4, 16'd0};
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10 && done_at == 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (done === 1'b1) done_at = i;
            checks++; if (last[0] !== 1'b1 || last[2] !== 1'b1) begin errors++; $display("FAIL t1_last i=%0d got=%b exp=1x1", i, last); end
            checks++; if (counts[15:0] !== 16'd0 || counts[47:32] !== 16'd0) begin errors++; $display("FAIL t1_outer i=%0d got=%h exp=0", i, counts); end
            if (i < 4) begin
                checks++; if (counts[31:16] !== 16'(i)) begin errors++; $display("FAIL t1_mid i=%0d got=%0d exp=%0d", i, counts[31:16], i); end
            end
        end
        checks++; if (done_at != 4) begin errors++; $display("FAIL t1_done_at got=%0d exp=4", done_at); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_continuous();
        int wraps = 0;
        targets = {16'd1, 16'd2, 16'd2};
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cont_busy i=%0d got=%b%b exp=10", i, busy, done); end
            checks++; if (counts !== exp_counts() || wrap !== m_wrap) begin errors++; $display("FAIL cont_counts i=%0d got=%h/%b exp=%h/%b", i, counts, wrap, exp_counts(), m_wrap); end
            if (i == 4) begin
                checks++; if (counts !== '0 || wrap !== 1'b1) begin errors++; $display("FAIL cont_wrap4 got=%h/%b exp=0/1", counts, wrap); end
            end
            if (wrap === 1'b1) wraps++;
        end
        checks++; if (wraps != 2) begin errors++; $display("FAIL cont_wraps got=%0d exp=2", wraps); end
        checks++; if (total !== 64'd8) begin errors++; $display("FAIL cont_total got=%0d exp=8", total); end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || counts !== '0) begin errors++; $display("FAIL cont_abort got=%b%b%b/%h exp=000/0", busy, done, wrap, counts); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cont_abort_done got=%b exp=0", done); end
    endtask

    task automatic test_abort_start();
        targets = {16'd2, 16'd2, 16'd3};
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || counts !== '0) begin errors++; $display("FAIL ab_idle got=%b%b/%h exp=00/0", busy, done, counts); end
        checks++; if (total !== m_total) begin errors++; $display("FAIL ab_total got=%0d exp=%0d", total, m_total); end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || total !== 64'd0 || counts !== '0) begin errors++; $display("FAIL ab_restart got=%b/%0d/%h exp=1/0/0", busy, total, counts); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (total !== 64'd2 || counts !== {16'd0, 16'd0, 16'd2}) begin errors++; $display("FAIL ab_run got=%0d/%h exp=2/000000000002", total, counts); end
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_and_reset();
        int seen_done = 0;
        targets = {16'd2, 16'd2, 16'd3};
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        targets = {16'd5, 16'd5, 16'd5};
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1 || counts !== {16'd0, 16'd0, 16'd2} || total !== 64'd2) begin errors++; $display("FAIL ign_run got=%b/%h/%0d exp=1/000000000002/2", busy, counts, total); end
        for (int i = 0; i < 20 && seen_done == 0; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (done === 1'b1) seen_done = 1;
        end
        checks++; if (seen_done != 1 || total !== 64'd12) begin errors++; $display("FAIL ign_done got=%0d/%0d exp=1/12", seen_done, total); end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0 || counts !== '0) begin errors++; $display("FAIL ign_done_start got=%b/%h exp=0/0", busy, counts); end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_stays_idle got=%b exp=0", busy); end
        targets = {16'd2, 16'd2, 16'd3};
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (counts !== '0 || last !== '0 || busy !== 1'b0 || step !== 1'b0) begin errors++; $display("FAIL rst_mid got=%h/%b/%b%b exp=0/000/00", counts, last, busy, step); end
        checks++; if (total !== 64'd0 || done !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL rst_mid_regs got=%0d/%b%b exp=0/00", total, done, wrap); end
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            targets = {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))};
            rst = ($urandom_range(0, 499) != 0);
            tick(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 9) < 7));
            checks++; if (counts !== exp_counts()) begin errors++; $display("FAIL rnd_counts n=%0d got=%h exp=%h", n, counts, exp_counts()); end
            checks++; if (last !== exp_last()) begin errors++; $display("FAIL rnd_last n=%0d got=%b exp=%b", n, last, exp_last()); end
            checks++; if (busy !== (m_state == 1) || step !== ((m_state == 1) && en)) begin errors++; $display("FAIL rnd_busy_step n=%0d got=%b%b exp=%b%b", n, busy, step, m_state == 1, (m_state == 1) && en); end
            checks++; if (wrap !== m_wrap || done !== m_done) begin errors++; $display("FAIL rnd_pulses n=%0d got=%b%b exp=%b%b", n, wrap, done, m_wrap, m_done); end
            checks++; if (total !== m_total) begin errors++; $display("FAIL rnd_total n=%0d got=%0d exp=%0d", n, total, m_total); end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_stall();
        test_target_one();
        test_continuous();
        test_abort_start();
        test_ignored_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
